dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port arbiter placed in front of the data memory / MMIO block. It shares one memory access per cycle between the pipeline MEM stage (port C) and a debug/loader master (port D, e.g. UART program loader). CPU has fixed priority. A starvation guard forces debug slots, and a lock mechanism lets debug hold the memory for short bursts. Stalls to the pipeline are generated here.

## Interface
Parameters:
- MAX_WAIT, 8: consecutive denied debug cycles before a forced debug grant (1..255)
- MAX_BURST, 4: maximum consecutive debug beats under d_lock (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- c_req  in  1  CPU MEM-stage access request (MemRead or MemWrite)
- c_we  in  1  CPU write (1) / read (0)
- c_lwlb  in  1  CPU byte-load select, passed through
- c_addr  in  32  CPU byte address
- c_wdata  in  32  CPU write data
- c_rdata  out  32  CPU read data, combinational from mem_rdata
- c_stall  out  1  CPU access not performed this cycle; hold the pipeline
- d_req  in  1  debug request
- d_we  in  1  debug write / read
- d_lock  in  1  request to keep ownership for the following beat
- d_addr  in  32  debug byte address
- d_wdata  in  32  debug write data
- d_gnt  out  1  debug access performed this cycle
- d_rvalid  out  1  registered: debug read data valid
- d_rdata  out  32  registered debug read data
- mem_addr, mem_wdata  out  32  to memory
- mem_read, mem_write, mem_lwlb  out  1  to memory
- mem_rdata  in  32  from memory (combinational read)

## Operation
- FSM owner state: OWN_CPU (reset), OWN_DBG.
- OWN_CPU grant decision (each cycle):
  - force = d_req && wait_cnt == MAX_WAIT → grant D.
  - else c_req → grant C.
  - else d_req → grant D.
  - else no grant.
- Granting D with d_lock=1 → next state OWN_DBG, burst_cnt = 1.
- OWN_DBG: D is granted whenever d_req=1. Each grant with d_lock=1 increments burst_cnt.
  - Return to OWN_CPU when d_req=0, d_lock=0, or burst_cnt reaches MAX_BURST after the grant.
  - C is always denied in OWN_DBG.
- wait_cnt:
  - increments, saturating at MAX_WAIT, when d_req=1 and D is not granted.
  - clears on any D grant or when d_req=0.
- Granted master drives mem_addr, mem_wdata, mem_read = !we, mem_write = we.
  - mem_lwlb = c_lwlb for C, 0 for D.
  - No grant: mem_read = mem_write = 0, mem_addr = mem_wdata = 0.
- c_stall = c_req && !grant_C. c_rdata = mem_rdata when grant_C, else 0.
- d_gnt = grant_D. On a D read grant, d_rdata <= mem_rdata and d_rvalid <= 1 in the next cycle. Otherwise d_rvalid <= 0 and d_rdata holds.
- Debug writes to MMIO addresses (0x4000000C, 0x40000010) are legal and pass through unchanged.

## Timing
- Reset values: state OWN_CPU, wait_cnt 0, burst_cnt 0, d_rvalid 0, d_rdata 0.
  - All combinational outputs then evaluate to 0 unless c_req/d_req are asserted.
- CPU access latency is 0 cycles: same-cycle grant and read data, matching the pipeline's combinational MEM stage.
- Debug read latency: d_gnt in cycle N, d_rvalid and d_rdata in cycle N+1.
- Worst-case debug wait is MAX_WAIT denied cycles, then a guaranteed grant.
- Worst-case CPU stall is MAX_BURST consecutive cycles per burst, plus one isolated forced cycle per starvation event.
- Reset asserted mid-burst: immediate return to OWN_CPU, counters cleared, d_rvalid dropped. A pending d_rvalid is lost.
- Simultaneous c_req and d_req in OWN_CPU below the threshold: C wins and wait_cnt increments.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation guard active as described.
- Not defined: wait_cnt is removed and the force term is constant 0. Arbitration is pure CPU priority, so debug can starve indefinitely under continuous c_req. Lock/burst behaviour is unchanged.

## Structure
- Shared package holds:
  - owner state encoding (OWN_CPU = 1'b0, OWN_DBG = 1'b1)
  - MMIO address constants (LED 0x4000000C, display 0x40000010, clock counter 0x40000014)
  - default MAX_WAIT/MAX_BURST
- One natural sub-module: dmem_arb_sat_counter (parameterised width, increment/clear, saturate at limit). It is instantiated for both wait_cnt and burst_cnt.

## Test plan
- c_req=1 read addr 0x10 with memory word 0xDEADBEEF, d_req=0 → mem_read=1, c_rdata=0xDEADBEEF, c_stall=0 same cycle.
- d_req=1 read addr 0x20 (holds 0x12345678), c_req=0 → d_gnt=1 in cycle N; d_rvalid=1 with d_rdata=0x12345678 in N+1.
- c_req and d_req held high, MAX_WAIT=8, guard enabled → eight C grants, then one cycle with d_gnt=1 and c_stall=1, then C resumes.
- Same stimulus with guard disabled → d_gnt never asserts over 100 cycles.
- d_lock=1 with d_req held, c_req=1, MAX_BURST=4 → exactly 4 consecutive d_gnt beats with c_stall=1, then C granted.
- reset pulsed during the second locked beat → next cycle c_req is granted, d_rvalid=0, state OWN_CPU.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, MMIO map
// and default arbitration limits.
// Build option: DMEM_ARB_STARVE_EN enables the debug starvation guard.
package dmem_arbiter_pkg;

  // Which master currently owns the memory port
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // MMIO map; debug accesses to these pass through untouched
  localparam logic [31:0] MMIO_LED_ADDR     = 32'h4000_000C;
  localparam logic [31:0] MMIO_DISPLAY_ADDR = 32'h4000_0010;
  localparam logic [31:0] MMIO_CLKCNT_ADDR  = 32'h4000_0014;

  // Default arbitration limits
  localparam int DEFAULT_MAX_WAIT  = 8;
  localparam int DEFAULT_MAX_BURST = 4;

  // Counter width covers both limits (1..255)
  localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear and increment together
// load 1, which starts a new run with the current event already counted.
module dmem_arb_sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count register: clear/restart has priority, otherwise saturating increment
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// (port C, fixed priority, zero latency) and a debug/loader master (port D).
// Debug may lock the port for bursts of up to MAX_BURST beats.
// Build option: DMEM_ARB_STARVE_EN forces a debug grant after MAX_WAIT denied
// cycles; without it arbitration is pure CPU priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = DEFAULT_MAX_WAIT,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic        clk,
  input  logic        reset,
  // CPU MEM stage
  input  logic        c_req,
  input  logic        c_we,
  input  logic        c_lwlb,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  // Debug / loader master
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // Memory / MMIO port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_lwlb,
  input  logic [31:0] mem_rdata
);

  owner_e             state, state_next;
  logic               grant_c, grant_d;
  logic               force_d;
  logic               burst_clr, burst_inc;
  logic [CNT_W-1:0]   burst_cnt;
  logic               last_beat;

`ifdef DMEM_ARB_STARVE_EN
  logic [CNT_W-1:0]   wait_cnt;
  logic               wait_inc;

  // Denied-debug counter: counts while debug waits, clears on grant or idle
  assign wait_inc = d_req && !grant_d;

  dmem_arb_sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (CNT_W'(MAX_WAIT))
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!wait_inc),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  // Starvation threshold reached: debug takes the next slot
  assign force_d = d_req && (wait_cnt == CNT_W'(MAX_WAIT));
`else
  assign force_d = 1'b0;
`endif

  // Beat counter for locked debug bursts
  dmem_arb_sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (CNT_W'(MAX_BURST))
  ) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (burst_clr),
    .inc   (burst_inc),
    .count (burst_cnt)
  );

  // The grant in progress would bring the burst to MAX_BURST beats
  assign last_beat = (burst_cnt >= CNT_W'(MAX_BURST - 1));

  // Owner state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OWN_CPU;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision and owner transitions
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    grant_c    = 1'b0;
    grant_d    = 1'b0;
    burst_clr  = 1'b0;
    burst_inc  = 1'b0;
    case (state)
      OWN_CPU: begin
        if (force_d) begin
          grant_d = 1'b1;
        end else if (c_req) begin
          grant_c = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        // A locked grant opens a burst with this beat already counted
        if (grant_d && d_lock && (MAX_BURST > 1)) begin
          state_next = OWN_DBG;
          burst_clr  = 1'b1;
          burst_inc  = 1'b1;
        end
      end
      OWN_DBG: begin
        grant_d = d_req;
        if (!d_req || !d_lock || last_beat) begin
          state_next = OWN_CPU;
          burst_clr  = 1'b1;
        end else begin
          burst_inc  = 1'b1;
        end
      end
      default: begin
        state_next = OWN_CPU;
      end
    endcase
  end

  // Memory port mux: granted master drives, idle port is all zeros
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_lwlb  = 1'b0;
    if (grant_c) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_read  = !c_we;
      mem_write = c_we;
      mem_lwlb  = c_lwlb;
    end else if (grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_read  = !d_we;
      mem_write = d_we;
    end
  end

  assign c_stall = c_req && !grant_c;
  assign c_rdata = grant_c ? mem_rdata : '0;
  assign d_gnt   = grant_d;

  // Debug read return: data and valid one cycle after a read grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else if (grant_d && !d_we) begin
      d_rvalid <= 1'b1;
      d_rdata  <= mem_rdata;
    end else begin
      d_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the arbiter.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAX_WAIT  = 8;
  localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 0, c_we = 0, c_lwlb = 0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [31:0] c_rdata;
  logic        c_stall;
  logic        d_req = 0, d_we = 0, d_lock = 0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_lwlb;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_lwlb(c_lwlb), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_lwlb(mem_lwlb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench-side memory: combinational read, write on clock edge
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: ownership as "debug holds the port", counters as ints
  bit          m_dbg_owns;
  int          m_denied;
  int          m_beats;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          e_gc, e_gd;
  logic [31:0] e_read_word;

  function automatic void model_reset();
    m_dbg_owns = 0; m_denied = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;
  endfunction

  // Apply one cycle of inputs at the falling edge and check all outputs
  task automatic drive(input bit cr, input bit cw, input bit cl,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input bit dl,
                       input logic [31:0] da, input logic [31:0] dd);
    logic [31:0] x_addr, x_wdata;
    bit x_rd, x_wr, x_lb;
    @(negedge clk);
    c_req = cr; c_we = cw; c_lwlb = cl; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
    #1;
    e_gc = 0; e_gd = 0;
    if (m_dbg_owns) e_gd = dr;
    else if (STARVE && dr && m_denied >= MAX_WAIT) e_gd = 1;
    else if (cr) e_gc = 1;
    else if (dr) e_gd = 1;
    x_addr = '0; x_wdata = '0; x_rd = 0; x_wr = 0; x_lb = 0;
    if (e_gc) begin x_addr = ca; x_wdata = cd; x_rd = !cw; x_wr = cw; x_lb = cl; end
    if (e_gd) begin x_addr = da; x_wdata = dd; x_rd = !dw; x_wr = dw; end
    e_read_word = mem[da[9:2]];
    check("c_stall",   32'(c_stall),   32'(cr && !e_gc));
    check("d_gnt",     32'(d_gnt),     32'(e_gd));
    check("mem_read",  32'(mem_read),  32'(x_rd));
    check("mem_write", 32'(mem_write), 32'(x_wr));
    check("mem_lwlb",  32'(mem_lwlb),  32'(x_lb));
    check("mem_addr",  mem_addr,       x_addr);
    check("mem_wdata", mem_wdata,      x_wdata);
    check("c_rdata",   c_rdata,        e_gc ? mem[ca[9:2]] : 32'h0);
    check("d_rvalid",  32'(d_rvalid),  32'(m_rvalid));
    check("d_rdata",   d_rdata,        m_rdata);
  endtask

  // Advance the model across the rising edge
  task automatic commit();
    @(posedge clk);
    if (e_gd && !d_we) begin m_rvalid = 1; m_rdata = e_read_word; end
    else m_rvalid = 0;
    if (d_req && !e_gd) m_denied = (m_denied + 1 > MAX_WAIT) ? MAX_WAIT : m_denied + 1;
    else m_denied = 0;
    if (!m_dbg_owns) begin
      if (e_gd && d_lock && MAX_BURST > 1) begin m_dbg_owns = 1; m_beats = 1; end
    end else begin
      if (e_gd && d_lock) m_beats++;
      if (!d_req || !d_lock || m_beats >= MAX_BURST) m_dbg_owns = 0;
    end
  endtask

  task automatic step(input bit cr, input bit cw, input logic [31:0] ca,
                      input bit dr, input bit dw, input bit dl, input logic [31:0] da);
    drive(cr, cw, 1'b0, ca, $urandom, dr, dw, dl, da, $urandom);
    commit();
  endtask

  // Asynchronous reset with idle inputs; released on a falling edge
  task automatic apply_reset();
    reset = 1'b1;
    c_req = 0; c_we = 0; c_lwlb = 0; d_req = 0; d_we = 0; d_lock = 0;
    #1;
    model_reset();
    check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    check("rst_d_rdata",  d_rdata,       32'h0);
    check("rst_d_gnt",    32'(d_gnt),    32'h0);
    check("rst_c_stall",  32'(c_stall),  32'h0);
    check("rst_mem_rw",   32'({mem_read, mem_write}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return MMIO_LED_ADDR;
    if (sel == 1) return MMIO_DISPLAY_ADDR;
    if (sel == 2) return MMIO_CLKCNT_ADDR;
    return {22'h0, 8'($urandom), 2'b00};
  endfunction

  initial begin
    bit gseq [0:99];
    bit sseq [0:99];
    int first_d, cnt, run;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h1234_5678;
    model_reset();
    apply_reset();

    // CPU read: same-cycle data, no stall
    drive(1, 0, 1, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    check("cpu_rd_mem_read", 32'(mem_read), 32'h1);
    check("cpu_rd_data",     c_rdata,       32'hDEAD_BEEF);
    check("cpu_rd_stall",    32'(c_stall),  32'h0);
    commit();

    // Debug read: grant in N, data in N+1
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0);
    check("dbg_rd_gnt", 32'(d_gnt), 32'h1);
    commit();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    check("dbg_rd_rvalid", 32'(d_rvalid), 32'h1);
    check("dbg_rd_rdata",  d_rdata,       32'h1234_5678);
    commit();

    // Debug write to MMIO passes through unchanged
    drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, MMIO_DISPLAY_ADDR, 32'hCAFE_0001);
    check("mmio_addr",  mem_addr,  MMIO_DISPLAY_ADDR);
    check("mmio_wdata", mem_wdata, 32'hCAFE_0001);
    commit();

    // Contention: both masters held high
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 0, rand_addr(), 32'h0, 1, 0, 0, 32'h20, 32'h0);
      gseq[i] = d_gnt; sseq[i] = c_stall;
      commit();
    end
    first_d = -1; cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (gseq[i]) cnt++;
      if (gseq[i] && first_d < 0) first_d = i;
    end
    if (STARVE) begin
      check("starve_first_d", 32'(first_d), 32'(MAX_WAIT));
      check("starve_stall",   32'(sseq[MAX_WAIT]), 32'h1);
      check("starve_resume",  32'(sseq[MAX_WAIT + 1]), 32'h0);
      check("starve_count",   32'(cnt), 32'(100 / (MAX_WAIT + 1)));
    end else begin
      check("nostarve_count", 32'(cnt), 32'h0);
    end

    // Locked burst: first beat while CPU idle, then CPU requests throughout
    apply_reset();
    step(0, 0, 32'h0, 1, 1, 1, rand_addr());
    run = 1;
    for (int i = 1; i < 8; i++) begin
      drive(1, 0, 0, rand_addr(), 32'h0, 1, 1, 1, rand_addr(), 32'h0);
      gseq[i] = d_gnt; sseq[i] = c_stall;
      commit();
    end
    for (int i = 1; i < 8 && gseq[i]; i++) run++;
    check("burst_len",        32'(run), 32'(MAX_BURST));
    check("burst_cpu_after",  32'(sseq[MAX_BURST]), 32'h0);

    // Reset during the second locked beat
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 1, 32'h20);
    drive(1, 0, 0, 32'h10, 32'h0, 1, 0, 1, 32'h20, 32'h0);
    check("midrst_beat2_gnt", 32'(d_gnt), 32'h1);
    apply_reset();
    drive(1, 0, 0, 32'h10, 32'h0, 1, 0, 1, 32'h20, 32'h0);
    check("midrst_cpu_gnt", 32'(c_stall),  32'h0);
    check("midrst_rvalid",  32'(d_rvalid), 32'h0);
    commit();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, 1'($urandom),
            rand_addr(), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            rand_addr(), $urandom);
      commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
